// File: rtl/move_sort_pkg.sv
// Shared constants for the move-ordering sorter: defaults, entry field offsets
// and the sort FSM encoding.
package move_sort_pkg;

  localparam int DEFAULT_RAM_WIDTH     = 64;
  localparam int DEFAULT_EVAL_WIDTH    = 24;
  localparam int DEFAULT_MAX_POSITIONS = 256;

  // Check flags sit directly above the eval field; offsets are relative to EVAL_WIDTH.
  localparam int EVAL_LSB        = 0;
  localparam int BLACK_CHECK_OFS = 0;
  localparam int WHITE_CHECK_OFS = 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_READ     = 3'd1;
  localparam logic [2:0] S_COMPARE  = 3'd2;
  localparam logic [2:0] S_WRITE    = 3'd3;
  localparam logic [2:0] S_PASS_END = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

endpackage

// File: rtl/move_sort_ram.sv
// True dual-port RAM, both ports read/write, registered read (read-before-write).
module move_sort_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] din_a,
  output logic [WIDTH-1:0] dout_a,
  input  logic             we_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] din_b,
  output logic [WIDTH-1:0] dout_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/move_sorter.sv
// Move-ordering buffer: appends generated moves, then bubble-sorts them in place
// (stable, early exit) best-first for the side to move, optionally checks first.
module move_sorter
  import move_sort_pkg::*;
#(
  parameter int RAM_WIDTH          = DEFAULT_RAM_WIDTH,
  parameter int EVAL_WIDTH         = DEFAULT_EVAL_WIDTH,
  parameter int MAX_POSITIONS      = DEFAULT_MAX_POSITIONS,
  parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sort_start,
  input  logic                          sort_clear,
  input  logic                          white_to_move,
  input  logic                          check_first,
  input  logic                          wr_addr_init,
  input  logic [RAM_WIDTH-1:0]          wr_data,
  input  logic                          wr,
  input  logic [MAX_POSITIONS_LOG2-1:0] rd_addr,
  output logic [RAM_WIDTH-1:0]          rd_data,
  output logic [MAX_POSITIONS_LOG2:0]   count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          sort_complete
);

  localparam int AW = MAX_POSITIONS_LOG2;

  logic [2:0]           state;
  logic [AW-1:0]        i, limit;
  logic                 swapped, swap_q, wtm_q, cf_q;
  logic [RAM_WIDTH-1:0] a_q, b_q, dout_a, dout_b;
  logic                 rd_live;
  logic [RAM_WIDTH-1:0] rd_hold;

  // Load path: init applies before a coincident write
  logic          idle, full, load_wr;
  logic [AW:0]   base_count, new_count;

  assign idle       = (state == S_IDLE);
  assign base_count = wr_addr_init ? '0 : count;
  assign full       = (base_count == (AW+1)'(MAX_POSITIONS));
  assign load_wr    = idle && wr && !full && !sort_clear && !reset;
  assign new_count  = base_count + (AW+1)'(load_wr);

  logic          swap_we;
  logic [AW-1:0] addr_a, addr_b;
  logic [RAM_WIDTH-1:0] din_b;

  assign swap_we = (state == S_WRITE) && swap_q;
  assign addr_a  = busy ? i : rd_addr;
  assign addr_b  = busy ? AW'(i + 1'b1) : base_count[AW-1:0];
  assign din_b   = busy ? a_q : wr_data;

  move_sort_ram #(.WIDTH(RAM_WIDTH), .DEPTH(MAX_POSITIONS), .AW(AW)) u_ram (
    .clk    (clk),
    .we_a   (swap_we),
    .addr_a (addr_a),
    .din_a  (b_q),
    .dout_a (dout_a),
    .we_b   (load_wr | swap_we),
    .addr_b (addr_b),
    .din_b  (din_b),
    .dout_b (dout_b)
  );

  // Swap only when B strictly precedes A, which keeps equal keys in order.
  logic signed [EVAL_WIDTH-1:0] ev_a, ev_b;
  logic ck_a, ck_b, b_first;

  always_comb begin
    ev_a = signed'(dout_a[EVAL_LSB +: EVAL_WIDTH]);
    ev_b = signed'(dout_b[EVAL_LSB +: EVAL_WIDTH]);
    ck_a = wtm_q ? dout_a[EVAL_WIDTH+BLACK_CHECK_OFS] : dout_a[EVAL_WIDTH+WHITE_CHECK_OFS];
    ck_b = wtm_q ? dout_b[EVAL_WIDTH+BLACK_CHECK_OFS] : dout_b[EVAL_WIDTH+WHITE_CHECK_OFS];
    if (cf_q && (ck_a != ck_b)) b_first = ck_b;
    else if (wtm_q)             b_first = (ev_b > ev_a);
    else                        b_first = (ev_b < ev_a);
  end

  always_ff @(posedge clk) begin
    if (reset || sort_clear) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      sort_complete <= 1'b0;
      count         <= '0;
      overflow      <= 1'b0;
      i             <= '0;
      limit         <= '0;
      swapped       <= 1'b0;
      swap_q        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          count <= new_count;
          if (wr_addr_init) overflow <= 1'b0;
          if (wr && full)   overflow <= 1'b1;
          if (wr_addr_init || load_wr) sort_complete <= 1'b0;
          if (sort_start) begin
            wtm_q         <= white_to_move;
            cf_q          <= check_first;
            i             <= '0;
            limit         <= AW'(new_count - 1'b1);
            swapped       <= 1'b0;
            busy          <= 1'b1;
            sort_complete <= 1'b0;
            state         <= (new_count < (AW+1)'(2)) ? S_DONE : S_READ;
          end
        end
        S_READ: state <= S_COMPARE;
        S_COMPARE: begin
          a_q    <= dout_a;
          b_q    <= dout_b;
          swap_q <= b_first;
          state  <= S_WRITE;
        end
        S_WRITE: begin
          if (swap_q) swapped <= 1'b1;
          i     <= AW'(i + 1'b1);
          state <= (AW'(i + 1'b1) == limit) ? S_PASS_END : S_READ;
        end
        S_PASS_END: begin
          if (!swapped || limit == AW'(1)) begin
            // Flags raised on the way into DONE so the final pass costs no extra cycle.
            busy          <= 1'b0;
            sort_complete <= 1'b1;
            state         <= S_DONE;
          end else begin
            limit   <= AW'(limit - 1'b1);
            i       <= '0;
            swapped <= 1'b0;
            state   <= S_READ;
          end
        end
        S_DONE: begin
          busy          <= 1'b0;
          sort_complete <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Port A output is the external read only when the previous cycle was not busy.
  assign rd_data = rd_live ? dout_a : rd_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_live <= 1'b0;
      rd_hold <= '0;
    end else begin
      rd_live <= !busy;
      rd_hold <= rd_data;
    end
  end

endmodule

// File: tb/tb_move_sorter.sv
// Directed bench for move_sorter: load, sort in both directions, check priority,
// stability, latency, overflow, clear and coincident-control cases.
module tb_move_sorter;

  localparam int RW = 64;
  localparam int EW = 24;
  localparam int MP = 8;
  localparam int LG = 3;

  logic          clk = 1'b0;
  logic          reset, sort_start, sort_clear, white_to_move, check_first;
  logic          wr_addr_init, wr;
  logic [RW-1:0] wr_data, rd_data;
  logic [LG-1:0] rd_addr;
  logic [LG:0]   count;
  logic          overflow, busy, sort_complete;

  int total = 0;
  int bad   = 0;

  move_sorter #(.RAM_WIDTH(RW), .EVAL_WIDTH(EW), .MAX_POSITIONS(MP)) dut (
    .clk(clk), .reset(reset), .sort_start(sort_start), .sort_clear(sort_clear),
    .white_to_move(white_to_move), .check_first(check_first),
    .wr_addr_init(wr_addr_init), .wr_data(wr_data), .wr(wr), .rd_addr(rd_addr),
    .rd_data(rd_data), .count(count), .overflow(overflow), .busy(busy),
    .sort_complete(sort_complete)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] mk(input int ev, input bit bic, input bit wic, input int tag);
    logic [RW-1:0] d;
    d        = '0;
    d[23:0]  = ev[23:0];
    d[24]    = bic;
    d[25]    = wic;
    d[39:32] = tag[7:0];
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_load();
    wr_addr_init = 1'b1;
    tick();
    wr_addr_init = 1'b0;
  endtask

  task automatic push(input logic [RW-1:0] d);
    wr      = 1'b1;
    wr_data = d;
    tick();
    wr      = 1'b0;
  endtask

  task automatic rd(input int idx, output logic [RW-1:0] d);
    rd_addr = idx[LG-1:0];
    tick();
    d = rd_data;
  endtask

  // lat = cycles from sort_start cycle t until sort_complete is seen (t+lat); -1 on timeout
  task automatic run_sort(input bit wtm, input bit cf, output int lat);
    white_to_move = wtm;
    check_first   = cf;
    sort_start    = 1'b1;
    tick();
    sort_start = 1'b0;
    lat = 1;
    while (!sort_complete && lat < 500) begin
      tick();
      lat++;
    end
    if (!sort_complete) lat = -1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++; if (rd_data !== '0)     begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    total++; if (count !== '0)       begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (sort_complete !== 1'b0) begin bad++; $display("FAIL reset_sort_complete got=%b want=0", sort_complete); end
  endtask

  task automatic load_basic();
    init_load();
    push(mk(5, 0, 0, 1));
    push(mk(-3, 0, 0, 2));
    push(mk(12, 0, 0, 3));
    push(mk(0, 0, 0, 4));
  endtask

  task automatic test_desc();
    logic [RW-1:0] e [4];
    logic [RW-1:0] d;
    int lat;
    e = '{mk(12,0,0,3), mk(5,0,0,1), mk(0,0,0,4), mk(-3,0,0,2)};
    load_basic();
    run_sort(1'b1, 1'b0, lat);
    total++; if (sort_complete !== 1'b1) begin bad++; $display("FAIL desc_complete got=%b want=1", sort_complete); end
    total++; if (count !== 4) begin bad++; $display("FAIL desc_count got=%0d want=4", count); end
    for (int k = 0; k < 4; k++) begin
      rd(k, d);
      total++; if (d !== e[k]) begin bad++; $display("FAIL desc_idx%0d got=%h want=%h", k, d, e[k]); end
    end
  endtask

  task automatic test_asc();
    logic [RW-1:0] e [4];
    logic [RW-1:0] d;
    int lat;
    e = '{mk(-3,0,0,2), mk(0,0,0,4), mk(5,0,0,1), mk(12,0,0,3)};
    load_basic();
    run_sort(1'b0, 1'b0, lat);
    total++; if (sort_complete !== 1'b1) begin bad++; $display("FAIL asc_complete got=%b want=1", sort_complete); end
    for (int k = 0; k < 4; k++) begin
      rd(k, d);
      total++; if (d !== e[k]) begin bad++; $display("FAIL asc_idx%0d got=%h want=%h", k, d, e[k]); end
    end
  endtask

  task automatic test_check_first();
    logic [RW-1:0] e [3];
    logic [RW-1:0] d;
    int lat;
    e = '{mk(9,1,0,3), mk(1,1,0,2), mk(7,0,0,1)};
    init_load();
    push(mk(7, 0, 0, 1));
    push(mk(1, 1, 0, 2));
    push(mk(9, 1, 0, 3));
    run_sort(1'b1, 1'b1, lat);
    for (int k = 0; k < 3; k++) begin
      rd(k, d);
      total++; if (d !== e[k]) begin bad++; $display("FAIL check_first_idx%0d got=%h want=%h", k, d, e[k]); end
    end
  endtask

  task automatic test_sorted_latency();
    logic [RW-1:0] e [4];
    logic [RW-1:0] d;
    int lat;
    e = '{mk(4,0,0,1), mk(3,0,0,2), mk(2,0,0,3), mk(1,0,0,4)};
    init_load();
    for (int k = 0; k < 4; k++) push(e[k]);
    run_sort(1'b1, 1'b0, lat);
    total++; if (lat !== 11) begin bad++; $display("FAIL sorted_latency got=%0d want=11", lat); end
    for (int k = 0; k < 4; k++) begin
      rd(k, d);
      total++; if (d !== e[k]) begin bad++; $display("FAIL sorted_idx%0d got=%h want=%h", k, d, e[k]); end
    end
  endtask

  task automatic test_stable();
    logic [RW-1:0] d;
    int lat;
    for (int dir = 0; dir < 2; dir++) begin
      init_load();
      push(mk(3, 0, 0, 8'hA));
      push(mk(3, 0, 0, 8'hB));
      push(mk(3, 0, 0, 8'hC));
      run_sort(dir[0], 1'b0, lat);
      for (int k = 0; k < 3; k++) begin
        rd(k, d);
        total++; if (d !== mk(3, 0, 0, 8'hA + k)) begin bad++; $display("FAIL stable_dir%0d_idx%0d got=%h want=%h", dir, k, d, mk(3, 0, 0, 8'hA + k)); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [RW-1:0] d;
    init_load();
    for (int k = 0; k <= MP; k++) push(mk(k, 0, 0, k));
    total++; if (count !== MP) begin bad++; $display("FAIL overflow_count got=%0d want=%0d", count, MP); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_flag got=%b want=1", overflow); end
    rd(MP - 1, d);
    total++; if (d !== mk(MP - 1, 0, 0, MP - 1)) begin bad++; $display("FAIL overflow_last got=%h want=%h", d, mk(MP - 1, 0, 0, MP - 1)); end
    // init coinciding with wr: init first, data lands at index 0
    wr_addr_init = 1'b1;
    push(mk(99, 0, 0, 9));
    wr_addr_init = 1'b0;
    total++; if (count !== 1) begin bad++; $display("FAIL init_wr_count got=%0d want=1", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL init_wr_overflow got=%b want=0", overflow); end
    rd(0, d);
    total++; if (d !== mk(99, 0, 0, 9)) begin bad++; $display("FAIL init_wr_idx0 got=%h want=%h", d, mk(99, 0, 0, 9)); end
  endtask

  task automatic test_clear();
    init_load();
    for (int k = 1; k <= 4; k++) push(mk(k, 0, 0, k));
    white_to_move = 1'b1;
    sort_start    = 1'b1;
    tick();
    sort_start = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy_before got=%b want=1", busy); end
    sort_clear = 1'b1;
    tick();
    sort_clear = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_busy got=%b want=0", busy); end
    total++; if (count !== 0) begin bad++; $display("FAIL clear_count got=%0d want=0", count); end
    total++; if (sort_complete !== 1'b0) begin bad++; $display("FAIL clear_complete got=%b want=0", sort_complete); end
  endtask

  task automatic test_single();
    int lat;
    init_load();
    push(mk(42, 0, 0, 1));
    run_sort(1'b1, 1'b0, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL single_latency got=%0d want=2", lat); end
  endtask

  task automatic test_start_with_wr();
    logic [RW-1:0] e [3];
    logic [RW-1:0] d;
    int lat;
    e = '{mk(3,0,0,3), mk(2,0,0,2), mk(1,0,0,1)};
    init_load();
    push(mk(1, 0, 0, 1));
    push(mk(2, 0, 0, 2));
    wr      = 1'b1;
    wr_data = mk(3, 0, 0, 3);
    white_to_move = 1'b1;
    check_first   = 1'b0;
    sort_start    = 1'b1;
    tick();
    wr = 1'b0;
    sort_start = 1'b0;
    lat = 1;
    while (!sort_complete && lat < 500) begin
      tick();
      lat++;
    end
    total++; if (sort_complete !== 1'b1) begin bad++; $display("FAIL start_wr_complete got=%b want=1", sort_complete); end
    tick();
    total++; if (count !== 3) begin bad++; $display("FAIL start_wr_count got=%0d want=3", count); end
    for (int k = 0; k < 3; k++) begin
      rd(k, d);
      total++; if (d !== e[k]) begin bad++; $display("FAIL start_wr_idx%0d got=%h want=%h", k, d, e[k]); end
    end
  endtask

  initial begin
    reset = 1'b1; sort_start = 1'b0; sort_clear = 1'b0; white_to_move = 1'b0;
    check_first = 1'b0; wr_addr_init = 1'b0; wr = 1'b0; wr_data = '0; rd_addr = '0;
    test_reset();
    test_desc();
    test_asc();
    test_check_first();
    test_sorted_latency();
    test_stable();
    test_overflow();
    test_clear();
    test_single();
    test_start_with_wr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_sorter.md
Name: move_sorter

Overview:
- Parametrised successor to the search's move-ordering RAM.
- Move generator streams candidate positions in. The block sorts them in place by evaluation, best move first for the side to move, with optional check-giving-first priority. The search then reads them back by index.
- Sits between move generation and the search control FSM. Adds depth and width generality, a real in-place stable sort, overflow detection and abort.

Parameters:
- RAM_WIDTH, 64, entry width in bits; must be ≥ EVAL_WIDTH+2.
- EVAL_WIDTH, 24, signed evaluation field, bits [EVAL_WIDTH-1:0].
- MAX_POSITIONS, 256, entry capacity; power of two, ≥ 2.
- MAX_POSITIONS_LOG2, $clog2(MAX_POSITIONS), index width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- sort_start  in  1  pulse: begin sort of loaded entries
- sort_clear  in  1  pulse: abort any sort, empty the buffer
- white_to_move  in  1  sampled at sort_start; 1 = descending eval, 0 = ascending
- check_first  in  1  sampled at sort_start; enables check priority
- wr_addr_init  in  1  reset load pointer to 0 (entry count to 0)
- wr_data  in  RAM_WIDTH  entry to append
- wr  in  1  append strobe
- rd_addr  in  MAX_POSITIONS_LOG2  read index
- rd_data  out  RAM_WIDTH  registered read data, 1-cycle latency
- count  out  MAX_POSITIONS_LOG2+1  number of loaded entries
- overflow  out  1  sticky: a write was attempted while full
- busy  out  1  sort in progress
- sort_complete  out  1  sorted data valid

Behaviour:
- Entry fields:
  - eval = signed [EVAL_WIDTH-1:0]
  - black_in_check = bit EVAL_WIDTH
  - white_in_check = bit EVAL_WIDTH+1
- Reset values: rd_data=0, count=0, overflow=0, busy=0, sort_complete=0, FSM=IDLE. RAM contents are not cleared.
- Load (IDLE only):
  - wr stores wr_data at index count, then count++.
  - If count==MAX_POSITIONS, the write is dropped and overflow is set.
  - wr_addr_init sets count=0 and clears overflow. If it coincides with wr, the init applies first and the data goes to index 0.
  - wr and wr_addr_init are ignored while busy.
  - Any accepted wr or wr_addr_init clears sort_complete.
- Read: rd_data <= mem[rd_addr] every cycle when not busy. While busy, rd_data holds its value. Indices ≥ count return stale contents.
- Order key for a before b, evaluated in this order:
  - If check_first: an entry where the opponent is in check precedes one where it is not. The opponent is black when white_to_move=1, white when white_to_move=0.
  - Otherwise, or when the check flags are equal: eval_a > eval_b if white_to_move, eval_a < eval_b if not.
  - Equal keys are never swapped, so the sort is stable.
- FSM (bubble sort with early exit):
  - IDLE: on sort_start go to READ. Set i=0, limit=count-1, swapped=0, busy=1, sort_complete=0.
    - If sort_start coincides with wr, the write is taken and included in count.
    - If count<2, go directly to DONE.
  - READ: issue reads at i (port A) and i+1 (port B).
  - COMPARE: data valid; compute swap.
  - WRITE: if swap, write A→i+1 and B→i and set swapped=1. Then i++. If i+1==limit go to PASS_END, else go to READ.
  - PASS_END: if !swapped or limit==1 go to DONE. Otherwise limit--, i=0, swapped=0, go to READ.
  - DONE: busy=0, sort_complete=1, return to IDLE.
- Timing: each compare takes exactly 3 cycles; each pass with k compares takes 3k+1 cycles. For an already-sorted n≥2 list with sort_start at cycle t, sort_complete is first high at t+3(n-1)+2.
- sort_clear (any state): next cycle FSM=IDLE, busy=0, sort_complete=0, count=0, overflow=0. It takes priority over sort_start and wr in the same cycle.
- sort_start while busy is ignored.
- Reset mid-sort: same effect as sort_clear plus the rd_data reset. RAM contents are undefined-order but not corrupted beyond the completed swaps.

Decomposition:
- Shared package (vchess.vh or a new move_sort_pkg):
  - MAX_POSITIONS default
  - entry field offset constants
  - FSM state encoding, localparams in the package
- Sub-module move_sort_ram:
  - true dual-port RAM, two read/write ports, 1-cycle registered read
  - parametrised RAM_WIDTH and depth
  - port A is shared between external access and the sorter through a busy-selected mux

Test Plan:
- Load evals {5,-3,12,0}, white_to_move=1, check_first=0, sort → read idx0..3 = {12,5,0,-3}; sort_complete asserted; count=4.
- Same load, white_to_move=0 → {-3,0,5,12}.
- Load {7 black_in_check=0, 1 black_in_check=1, 9 black_in_check=1}, white_to_move=1, check_first=1 → order {9,1,7}.
- Already-sorted {4,3,2,1}, white_to_move=1, sort_start at cycle t → sort_complete first high at t+11; no writes observed.
- Stability and ties: load {3(tagA),3(tagB),3(tagC)}, any direction → tags remain A,B,C.
- Boundaries:
  - Load MAX_POSITIONS+1 entries → count=MAX_POSITIONS, overflow=1.
  - sort_clear mid-sort → busy=0 and count=0 next cycle.
  - sort_start with count=1 → sort_complete at t+2.
